arrow_scheduler: RTL and testbench

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

---
 rtl/arrow_pkg.sv | 37 +++
 rtl/arrow_slot_picker.sv | 50 +++++
 rtl/arrow_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_arrow_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arrow_pkg.sv
// arrow_pkg: shared lane/slot types, default lane geometry and small helpers
// used by the arrow scheduler and its slot picker.
package arrow_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } lane_t;

    typedef struct packed {
        logic        active;
        logic [10:0] x;
        logic [9:0]  y;
        lane_t       rotate;
    } slot_t;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } sched_state_t;

    localparam int DEF_LANE_X0    = 400;
    localparam int DEF_LANE_PITCH = 48;

    // Screen x of a lane's column.
    function automatic logic [10:0] lane_x(lane_t lane, int x0, int pitch);
        return 11'(x0 + int'(lane) * pitch);
    endfunction

    // True when y lies in the inclusive range [lo, hi].
    function automatic logic y_in_range(logic [9:0] y, int lo, int hi);
        return (int'(y) >= lo) && (int'(y) <= hi);
    endfunction

endpackage

// File: rtl/arrow_slot_picker.sv
// arrow_slot_picker: combinational selection of the lowest-index free slot
// and of the target slot (largest y among active slots, ties to lowest index).
module arrow_slot_picker
    import arrow_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  slot_t                slots [NUM_SLOTS],
    output logic                 free_valid,
    output logic [IDX_W-1:0]     free_idx,
    output logic                 target_valid,
    output logic [IDX_W-1:0]     target_idx,
    output logic [NUM_SLOTS-1:0] target_onehot
);

    logic [9:0] best_y;

    // Lowest free slot: scan downwards so the last hit is the lowest index.
    always_comb begin
        // NOTE: blocking assignments in combinational logic give loop order
        // priority; every output gets a default first so no latch is inferred.
        free_valid = 1'b0;
        free_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slots[i].active) begin
                free_valid = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Target: strict greater-than keeps the lowest index on equal y.
    always_comb begin
        target_valid  = 1'b0;
        target_idx    = '0;
        target_onehot = '0;
        best_y        = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slots[i].active && (!target_valid || slots[i].y > best_y)) begin
                target_valid     = 1'b1;
                target_idx       = IDX_W'(i);
                best_y           = slots[i].y;
                target_onehot    = '0;
                target_onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arrow_scheduler.sv
// arrow_scheduler: moves falling arrows one slot per cycle after each frame
// pulse, accepts spawns while idle and judges player hits against the lowest
// arrow on screen. Define ARROW_SCHED_AUTOPLAY_EN to replace player input with
// an automatic hit as the target enters the lower half of the hit window.
module arrow_scheduler
    import arrow_pkg::*;
#(
    parameter int NUM_SLOTS  = 4,
    parameter int SPEED      = 2,
    parameter int Y_HIT      = 600,
    parameter int HIT_WINDOW = 24,
    parameter int Y_MISS     = 720,
    parameter int LANE_X0    = DEF_LANE_X0,
    parameter int LANE_PITCH = DEF_LANE_PITCH
) (
    input  logic                 clk_pixel,
    input  logic                 rst_in,
    input  logic                 new_frame_in,
    input  logic                 spawn_valid_in,
    input  logic [1:0]           spawn_lane_in,
    output logic                 spawn_ready_out,
    input  logic                 hit_in,
    input  logic [1:0]           hit_lane_in,
    output logic [10:0]          x_out      [NUM_SLOTS],
    output logic [9:0]           y_out      [NUM_SLOTS],
    output logic [1:0]           rotate_out [NUM_SLOTS],
    output logic [NUM_SLOTS-1:0] active_out,
    output logic [NUM_SLOTS-1:0] next_out,
    output logic [15:0]          hit_count_out,
    output logic [15:0]          miss_count_out
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    sched_state_t         state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 in_idle, in_update;

    slot_t                slots_q [NUM_SLOTS];
    slot_t                slots_d [NUM_SLOTS];
    logic [15:0]          hit_cnt_q, hit_cnt_d;
    logic [15:0]          miss_cnt_q, miss_cnt_d;
    logic                 hit_pend_q, hit_pend_d;
    lane_t                hit_lane_q, hit_lane_d;
    logic [10:0]          y_step;

    // Picker results for the post-edge slot array, registered so that the
    // free slot and target used in a cycle always describe slots_q.
    logic                 ready_q;
    logic [IDX_W-1:0]     free_idx_q;
    logic                 target_valid_q;
    logic [IDX_W-1:0]     target_idx_q;
    logic [NUM_SLOTS-1:0] next_q;

    logic                 pk_free_valid, pk_target_valid;
    logic [IDX_W-1:0]     pk_free_idx, pk_target_idx;
    logic [NUM_SLOTS-1:0] pk_onehot;

    logic                 spawn_fire;
    logic                 hit_ok;

    arrow_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
        .slots        (slots_d),
        .free_valid   (pk_free_valid),
        .free_idx     (pk_free_idx),
        .target_valid (pk_target_valid),
        .target_idx   (pk_target_idx),
        .target_onehot(pk_onehot)
    );

    // FSM state register; reset abandons any sweep in progress.
    always_ff @(posedge clk_pixel) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: a frame pulse starts a sweep; pulses mid-sweep are dropped.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (new_frame_in) begin
                    state_d = UPDATE;
                    idx_d   = '0;
                end
            end
            UPDATE: begin
                if (idx_q == IDX_W'(NUM_SLOTS - 1)) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: phase decodes consumed by the datapath.
    always_comb begin
        in_idle   = (state_q == IDLE);
        in_update = (state_q == UPDATE);
    end

    assign spawn_fire = in_idle && spawn_valid_in && ready_q;

`ifdef ARROW_SCHED_AUTOPLAY_EN
    // Automatic hit as soon as the target is in [Y_HIT-HIT_WINDOW, Y_HIT].
    assign hit_ok = in_idle && target_valid_q &&
                    y_in_range(slots_q[target_idx_q].y, Y_HIT - HIT_WINDOW, Y_HIT);

    logic unused_hit_inputs;
    assign unused_hit_inputs = ^{hit_in, hit_lane_in, hit_pend_q, hit_lane_q};
`else
    // A fresh press wins over a press latched during the sweep.
    lane_t hit_req_lane;
    assign hit_req_lane = hit_in ? lane_t'(hit_lane_in) : hit_lane_q;
    assign hit_ok = in_idle && (hit_in || hit_pend_q) && target_valid_q &&
                    (slots_q[target_idx_q].rotate == hit_req_lane) &&
                    y_in_range(slots_q[target_idx_q].y,
                               Y_HIT - HIT_WINDOW, Y_HIT + HIT_WINDOW);
`endif

    // Datapath next state: sweep one slot per UPDATE cycle, spawn and judge in IDLE.
    always_comb begin
        slots_d    = slots_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        hit_pend_d = hit_pend_q;
        hit_lane_d = hit_lane_q;
        y_step     = '0;
        if (in_update) begin
            if (hit_in) begin
                hit_pend_d = 1'b1;
                hit_lane_d = lane_t'(hit_lane_in);
            end
            if (slots_q[idx_q].active) begin
                y_step = 11'(slots_q[idx_q].y) + 11'(SPEED);
                slots_d[idx_q].y = y_step[9:0];
                if (y_step > 11'(Y_MISS)) begin
                    slots_d[idx_q].active = 1'b0;
                    if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
                end
            end
        end else begin
            hit_pend_d = 1'b0;
            // free_idx_q was chosen before this cycle's hit, so both complete.
            if (spawn_fire) begin
                slots_d[free_idx_q].active = 1'b1;
                slots_d[free_idx_q].x      = lane_x(lane_t'(spawn_lane_in), LANE_X0, LANE_PITCH);
                slots_d[free_idx_q].y      = '0;
                slots_d[free_idx_q].rotate = lane_t'(spawn_lane_in);
            end
            if (hit_ok) begin
                slots_d[target_idx_q].active = 1'b0;
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end
        end
    end

    // Datapath registers and registered picker results.
    always_ff @(posedge clk_pixel) begin
        if (rst_in) begin
            // NOTE: the slot array is a handful of flops, not a RAM, so it is
            // cleared on reset like any other state.
            slots_q        <= '{default: '0};
            hit_cnt_q      <= '0;
            miss_cnt_q     <= '0;
            hit_pend_q     <= 1'b0;
            hit_lane_q     <= UP;
            ready_q        <= 1'b1;
            free_idx_q     <= '0;
            target_valid_q <= 1'b0;
            target_idx_q   <= '0;
            next_q         <= '0;
        end else begin
            slots_q        <= slots_d;
            hit_cnt_q      <= hit_cnt_d;
            miss_cnt_q     <= miss_cnt_d;
            hit_pend_q     <= hit_pend_d;
            hit_lane_q     <= hit_lane_d;
            ready_q        <= (state_d == IDLE) && pk_free_valid;
            free_idx_q     <= pk_free_idx;
            target_valid_q <= pk_target_valid;
            target_idx_q   <= pk_target_idx;
            next_q         <= pk_onehot;
        end
    end

    // Per-slot sprite drive straight from the slot registers.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            x_out[i]      = slots_q[i].x;
            y_out[i]      = slots_q[i].y;
            rotate_out[i] = slots_q[i].rotate;
            active_out[i] = slots_q[i].active;
        end
    end

    assign spawn_ready_out = ready_q;
    assign next_out        = next_q;
    assign hit_count_out   = hit_cnt_q;
    assign miss_count_out  = miss_cnt_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// tb_arrow_scheduler: self-checking bench for arrow_scheduler with default
// parameters. Window-boundary vectors come from a table, corner cases are
// hand-written sequences, and a random phase is compared against a slot model.
`timescale 1ns/1ps
module tb_arrow_scheduler;

    localparam int NS    = 4;
    localparam int SPD   = 2;
    localparam int YH    = 600;
    localparam int WIN   = 24;
    localparam int YM    = 720;
    localparam int X0    = 400;
    localparam int PITCH = 48;

    logic          clk_pixel = 1'b0;
    logic          rst_in, new_frame_in, spawn_valid_in, hit_in;
    logic [1:0]    spawn_lane_in, hit_lane_in;
    logic          spawn_ready_out;
    logic [10:0]   x_out      [NS];
    logic [9:0]    y_out      [NS];
    logic [1:0]    rotate_out [NS];
    logic [NS-1:0] active_out, next_out;
    logic [15:0]   hit_count_out, miss_count_out;

    int n_tests = 0;
    int n_fail  = 0;

    arrow_scheduler dut (
        .clk_pixel      (clk_pixel),
        .rst_in         (rst_in),
        .new_frame_in   (new_frame_in),
        .spawn_valid_in (spawn_valid_in),
        .spawn_lane_in  (spawn_lane_in),
        .spawn_ready_out(spawn_ready_out),
        .hit_in         (hit_in),
        .hit_lane_in    (hit_lane_in),
        .x_out          (x_out),
        .y_out          (y_out),
        .rotate_out     (rotate_out),
        .active_out     (active_out),
        .next_out       (next_out),
        .hit_count_out  (hit_count_out),
        .miss_count_out (miss_count_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    // ---------------- reference model: arrows as plain integers ----------------
    bit m_act [NS];
    int m_x   [NS];
    int m_y   [NS];
    int m_rot [NS];
    int m_hits, m_miss;

    function automatic void m_reset();
        for (int i = 0; i < NS; i++) begin
            m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_rot[i] = 0;
        end
        m_hits = 0; m_miss = 0;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < NS; i++) if (!m_act[i]) return i;
        return -1;
    endfunction

    function automatic int m_target();
        int t = -1;
        for (int i = 0; i < NS; i++)
            if (m_act[i] && (t < 0 || m_y[i] > m_y[t])) t = i;
        return t;
    endfunction

    function automatic void m_spawn_at(int f, int lane);
        if (f < 0) return;
        m_act[f] = 1; m_y[f] = 0; m_rot[f] = lane; m_x[f] = X0 + lane * PITCH;
    endfunction

    function automatic void m_hit(int lane);
        int t = m_target();
        int d;
        if (t < 0) return;
        d = m_y[t] - YH;
        if (d < 0) d = -d;
        if (m_rot[t] == lane && d <= WIN) begin
            m_act[t] = 0;
            if (m_hits < 65535) m_hits++;
        end
    endfunction

    function automatic void m_frame();
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                m_y[i] += SPD;
                if (m_y[i] > YM) begin
                    m_act[i] = 0;
                    if (m_miss < 65535) m_miss++;
                end
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic do_reset();
        rst_in = 1'b1; new_frame_in = 1'b0; spawn_valid_in = 1'b0; hit_in = 1'b0;
        spawn_lane_in = 2'd0; hit_lane_in = 2'd0;
        tick(); tick();
        rst_in = 1'b0;
        m_reset();
    endtask

    task automatic spawn(input logic [1:0] lane);
        spawn_valid_in = 1'b1; spawn_lane_in = lane;
        tick();
        spawn_valid_in = 1'b0;
    endtask

    task automatic hit_idle(input logic [1:0] lane);
        hit_in = 1'b1; hit_lane_in = lane;
        tick();
        hit_in = 1'b0;
    endtask

    // One frame: pulse, NS sweep cycles (optional hits / stray pulse), then one
    // idle cycle so any latched hit has been judged.
    task automatic run_frame(input int ha, input logic [1:0] la,
                             input int hb, input logic [1:0] lb, input int dup);
        new_frame_in = 1'b1;
        tick();
        for (int c = 0; c < NS; c++) begin
            hit_in       = (c == ha) || (c == hb);
            hit_lane_in  = (c == hb) ? lb : la;
            new_frame_in = (c == dup);
            tick();
        end
        hit_in = 1'b0; new_frame_in = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        repeat (n) run_frame(-1, 2'd0, -1, 2'd0, -1);
    endtask

    task automatic check_model(input string tag);
        logic [NS-1:0] ea, en;
        int t;
        ea = '0; en = '0;
        for (int i = 0; i < NS; i++) ea[i] = m_act[i];
        t = m_target();
        if (t >= 0) en[t] = 1'b1;
        check({tag, " active"}, 32'(active_out), 32'(ea));
        check({tag, " next"}, 32'(next_out), 32'(en));
        check({tag, " hits"}, 32'(hit_count_out), 32'(m_hits));
        check({tag, " misses"}, 32'(miss_count_out), 32'(m_miss));
        check({tag, " ready"}, 32'(spawn_ready_out), 32'(m_free() >= 0));
        for (int i = 0; i < NS; i++)
            if (m_act[i])
                check({tag, " slot xyr"}, {9'd0, x_out[i], y_out[i], rotate_out[i]},
                      {9'd0, 11'(m_x[i]), 10'(m_y[i]), 2'(m_rot[i])});
    endtask

    typedef struct {
        int         frames;
        logic [1:0] lane;
        logic [1:0] hlane;
        logic       exp_hit;
    } win_vec_t;

    win_vec_t vecs [7];
    int r, ha, hb, dup, f, t;
    logic [1:0] la, lb, ln;

    initial begin
        vecs[0] = '{290, 2'd2, 2'd2, 1'b1};  // y=580, in window
        vecs[1] = '{285, 2'd2, 2'd2, 1'b0};  // y=570, too early
        vecs[2] = '{288, 2'd1, 2'd1, 1'b1};  // y=576, lower edge inclusive
        vecs[3] = '{287, 2'd1, 2'd1, 1'b0};  // y=574, just outside
        vecs[4] = '{312, 2'd3, 2'd3, 1'b1};  // y=624, upper edge inclusive
        vecs[5] = '{313, 2'd3, 2'd3, 1'b0};  // y=626, just outside
        vecs[6] = '{300, 2'd0, 2'd1, 1'b0};  // y=600, wrong lane

        do_reset();
        check("reset active", 32'(active_out), 32'd0);
        check("reset next", 32'(next_out), 32'd0);
        check("reset hits", 32'(hit_count_out), 32'd0);
        check("reset misses", 32'(miss_count_out), 32'd0);
        check("reset ready", 32'(spawn_ready_out), 32'd1);
        for (int i = 0; i < NS; i++)
            check("reset slot xyr", {9'd0, x_out[i], y_out[i], rotate_out[i]}, 32'd0);

`ifdef ARROW_SCHED_AUTOPLAY_EN
        spawn(2'd1);
        frames(287);
        check("auto y574 hits", 32'(hit_count_out), 32'd0);
        check("auto y574 active", 32'(active_out), 32'b0001);
        frames(1);
        check("auto y576 hits", 32'(hit_count_out), 32'd1);
        check("auto y576 active", 32'(active_out), 32'd0);
        spawn(2'd2);
        hit_idle(2'd2);
        check("auto hit_in ignored", 32'(hit_count_out), 32'd1);
        check("auto spawn active", 32'(active_out), 32'b0001);
`else
        // First spawn lands in slot 0.
        spawn(2'd2);
        check("spawn active", 32'(active_out), 32'b0001);
        check("spawn x", 32'(x_out[0]), 32'd496);
        check("spawn y", 32'(y_out[0]), 32'd0);
        check("spawn rot", 32'(rotate_out[0]), 32'd2);
        check("spawn next", 32'(next_out), 32'b0001);

        // Fill all slots back to back, then hold a fifth request.
        do_reset();
        spawn_valid_in = 1'b1;
        for (int l = 0; l < NS; l++) begin
            spawn_lane_in = 2'(l);
            tick();
        end
        check("full ready", 32'(spawn_ready_out), 32'd0);
        spawn_lane_in = 2'd2;
        tick(); tick(); tick();
        spawn_valid_in = 1'b0;
        check("full active", 32'(active_out), 32'b1111);
        check("full slot3 x", 32'(x_out[3]), 32'd544);
        check("full slot3 rot", 32'(rotate_out[3]), 32'd3);
        check("full next tie", 32'(next_out), 32'b0001);

        // Hit-window table.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            spawn(vecs[v].lane);
            frames(vecs[v].frames);
            check("win y", 32'(y_out[0]), 32'(SPD * vecs[v].frames));
            hit_idle(vecs[v].hlane);
            check("win hits", 32'(hit_count_out), 32'(vecs[v].exp_hit));
            check("win active", 32'(active_out[0]), 32'(!vecs[v].exp_hit));
        end

        // Reset in the middle of the sweep that would retire the arrow.
        do_reset();
        spawn(2'd0);
        frames(360);
        check("y720 active", 32'(active_out), 32'b0001);
        check("y720 misses", 32'(miss_count_out), 32'd0);
        new_frame_in = 1'b1; tick(); new_frame_in = 1'b0;
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        check("midreset misses", 32'(miss_count_out), 32'd0);
        check("midreset active", 32'(active_out), 32'd0);
        check("midreset ready", 32'(spawn_ready_out), 32'd1);
        tick(); tick(); tick(); tick();
        check("midreset no sweep", 32'(miss_count_out), 32'd0);

        // Retire as miss after passing Y_MISS.
        m_reset();
        spawn(2'd0);
        frames(361);
        check("miss y", 32'(y_out[0]), 32'd722);
        check("miss active", 32'(active_out), 32'd0);
        check("miss count", 32'(miss_count_out), 32'd1);

        // Hits latched during the sweep; the later lane wins.
        do_reset();
        spawn(2'd1);
        frames(300);
        new_frame_in = 1'b1; tick(); new_frame_in = 1'b0;
        hit_in = 1'b1; hit_lane_in = 2'd3; tick();
        hit_lane_in = 2'd1; tick();
        hit_in = 1'b0;
        tick(); tick();
        check("latch pending hits", 32'(hit_count_out), 32'd0);
        tick();
        check("latch judged hits", 32'(hit_count_out), 32'd1);
        check("latch judged active", 32'(active_out), 32'd0);

        // Spawn and hit together: free slot is picked before the hit retires one.
        do_reset();
        spawn(2'd0);
        frames(300);
        spawn_valid_in = 1'b1; spawn_lane_in = 2'd3;
        hit_in = 1'b1; hit_lane_in = 2'd0;
        tick();
        spawn_valid_in = 1'b0; hit_in = 1'b0;
        check("spawn+hit active", 32'(active_out), 32'b0010);
        check("spawn+hit hits", 32'(hit_count_out), 32'd1);
        check("spawn+hit x", 32'(x_out[1]), 32'd544);

        // Random operations against the model.
        do_reset();
        for (int op = 0; op < 1200; op++) begin
            r = $urandom_range(0, 99);
            t = m_target();
            ln = ($urandom_range(0, 1) == 1 && t >= 0) ? 2'(m_rot[t]) : 2'($urandom_range(0, 3));
            if (r < 55) begin
                ha = -1; hb = -1; dup = -1;
                la = ln; lb = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) ha = $urandom_range(0, NS - 1);
                if (ha >= 0 && $urandom_range(0, 3) == 0) hb = $urandom_range(ha, NS - 1);
                if ($urandom_range(0, 4) == 0) dup = $urandom_range(0, NS - 1);
                run_frame(ha, la, hb, lb, dup);
                m_frame();
                if (hb >= 0) m_hit(int'(lb));
                else if (ha >= 0) m_hit(int'(la));
            end else if (r < 70) begin
                lb = 2'($urandom_range(0, 3));
                f = m_free();
                spawn(lb);
                m_spawn_at(f, int'(lb));
            end else if (r < 80) begin
                hit_idle(ln);
                m_hit(int'(ln));
            end else if (r < 88) begin
                lb = 2'($urandom_range(0, 3));
                f = m_free();
                spawn_valid_in = 1'b1; spawn_lane_in = lb;
                hit_in = 1'b1; hit_lane_in = ln;
                tick();
                spawn_valid_in = 1'b0; hit_in = 1'b0;
                m_hit(int'(ln));
                m_spawn_at(f, int'(lb));
            end else begin
                tick();
            end
            check_model("rand");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
